mt_info_sched: RTL and testbench
================================

Name: mt_info_sched

Overview:
- Round-robin scheduler and controller for the MT info shift-buffer path.
- Arbitrates NUM_REQ producers into a DEPTH-entry in-order queue of 32-bit MT info words, each tagged with its source ID.
- Drains the queue to one consumer over a valid/ready handshake.
- Owns the enable/drain/flush sequencing and reports buffer state on state_check.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- DEPTH, 5, queue entries (2..16).
- DATA_W, 32, MT info word width.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- enable  in  1  level; start/continue accepting requests.
- flush  in  1  pulse; stop accepting and drain the queue.
- req_valid  in  NUM_REQ  per-requester valid.
- req_data  in  NUM_REQ*DATA_W  requester i occupies bits [i*DATA_W +: DATA_W].
- req_ready  out  NUM_REQ  one-hot grant/accept.
- out_valid  out  1  head entry valid.
- out_ready  in  1  consumer accepts.
- out_data  out  DATA_W  head MT info word.
- out_src  out  clog2(NUM_REQ)  source ID of the head entry.
- WE  out  1  push strobe (entry written this cycle).
- RE  out  1  pop strobe (entry consumed this cycle).
- count  out  clog2(DEPTH+1)  current occupancy.
- state_check  out  3  {full, state[1:0]}.

Behaviour:
- Reset (synchronous, rst=1 at a clk edge):
  - state=IDLE, count=0, read/write pointers=0, RR pointer=0.
  - Outputs: req_ready=0, out_valid=0, WE=0, RE=0, state_check=3'b000.
  - Any stored entries are discarded, including on reset mid-operation.
- FSM encoding: IDLE=2'd0, RUN=2'd1, DRAIN=2'd2. 2'd3 is illegal and returns to IDLE on the next edge.
- FSM transitions:
  - IDLE→RUN when enable=1 and flush=0.
  - RUN→DRAIN when flush=1 or enable=0.
  - DRAIN→IDLE when count==0 and no pop is pending. If count==0 on entry, DRAIN lasts one cycle, then IDLE.
  - IDLE with flush=1: stay IDLE.
- Arbitration (combinational grant):
  - Active only in RUN with count<DEPTH.
  - Grant the first i with req_valid[i]=1, searching from RR pointer upward, modulo NUM_REQ.
  - req_ready = onehot(grant), else 0.
  - After a push, RR pointer = grant+1 mod NUM_REQ. With no push, the pointer holds.
- Push: WE = |req_ready & req_valid[grant]. Writes req_data slice and grant ID at the write pointer. Write pointer wraps DEPTH-1→0.
- Pop:
  - out_valid = (count!=0) and state!=IDLE.
  - out_data/out_src come from the head entry with 0-cycle latency from storage.
  - RE = out_valid & out_ready. Read pointer wraps DEPTH-1→0.
- Count update:
  - +1 on push only, −1 on pop only.
  - Unchanged on simultaneous push and pop.
- Full/empty boundaries:
  - Push is only allowed when count<DEPTH. At count==DEPTH, req_ready=0 even if a pop occurs in the same cycle (no bypass).
  - Pop is only allowed when count>0.
  - full = (count==DEPTH).
- Latency: a word pushed at edge N is visible on out_data at N+1 if the queue was empty.
- Flush and enable priority: flush in the same cycle as a grant blocks that grant, because state is still RUN but flush forces req_ready=0.
- out_valid/out_data are held stable while out_ready=0.
- Assertions:
  - req_ready is one-hot or zero.
  - count never exceeds DEPTH.
  - No RE when count==0.

Test Plan:
- Reset, then enable=1; req_valid=4'b1111 with data 0xA0..0xA3; out_ready=1 → grants in order 0,1,2,3; out_src sequence 0,1,2,3; out_data 0xA0,0xA1,0xA2,0xA3.
- out_ready=0; requester 2 streams 0x100..0x106 → 5 accepted (count=5, state_check=3'b101); req_ready=0 for 0x105. Raise out_ready → 0x100 pops first; 0x105 is accepted only after count drops to 4.
- Count=3, push and pop in the same cycle → count stays 3; WE=RE=1; pointers wrap correctly across entry index 4→0.
- RUN with count=2, pulse flush alongside req_valid[1]=1 → no grant that cycle; state=DRAIN (2'b10); both entries drain; then IDLE, state_check=3'b000.
- rst asserted with count=4 and out_valid=1 → next cycle count=0, out_valid=0, req_ready=0; re-enable → first grant goes to requester 0.
- Requesters 1 and 3 continuously valid → grants alternate 1,3,1,3; no starvation over 20 cycles.

Source files
------------

// File: rtl/mt_info_sched.sv
// mt_info_sched: round-robin arbiter that feeds an in-order queue of MT info
// words (tagged with source ID), drained to one consumer over valid/ready,
// with IDLE/RUN/DRAIN sequencing reported on state_check.
module mt_info_sched #(
  parameter  int NUM_REQ = 4,
  parameter  int DEPTH   = 5,
  parameter  int DATA_W  = 32,
  localparam int SRC_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
  localparam int CNT_W   = $clog2(DEPTH + 1)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      enable,
  input  logic                      flush,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [DATA_W-1:0]         out_data,
  output logic [SRC_W-1:0]          out_src,
  output logic                      WE,
  output logic                      RE,
  output logic [CNT_W-1:0]          count,
  output logic [2:0]                state_check
);

  localparam int PTR_W = $clog2(DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  typedef struct packed {
    logic [SRC_W-1:0]  src;
    logic [DATA_W-1:0] data;
  } entry_t;

  state_e           state_q, state_d;
  entry_t           mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [SRC_W-1:0] rr_q, rr_d;

  logic [SRC_W-1:0] scan_idx;
  logic [SRC_W-1:0] grant;
  logic             grant_found;
  logic             full;
  logic             push;
  logic             pop;
  entry_t           push_entry;

  assign full = (count_q == CNT_W'(DEPTH));

  // Round-robin search for the first valid requester at or above rr_q.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    scan_idx    = '0;
    grant       = '0;
    grant_found = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      scan_idx = SRC_W'((int'(rr_q) + i) % NUM_REQ);
      if (!grant_found && req_valid[scan_idx]) begin
        grant       = scan_idx;
        grant_found = 1'b1;
      end
    end
  end

  // Grant is only honoured in RUN, with room in the queue and no flush this cycle.
  assign push       = (state_q == ST_RUN) && !flush && !full && grant_found;
  assign req_ready  = push ? (NUM_REQ'(1) << grant) : '0;
  assign WE         = push;
  assign push_entry = '{src: grant, data: req_data[int'(grant)*DATA_W +: DATA_W]};

  assign out_valid   = (count_q != '0) && (state_q != ST_IDLE);
  assign pop         = out_valid && out_ready;
  assign RE          = pop;
  assign out_data    = mem_q[rd_ptr_q].data;
  assign out_src     = mem_q[rd_ptr_q].src;
  assign count       = count_q;
  assign state_check = {full, state_q};

  // Next-state for pointers, occupancy and the round-robin pointer.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    rr_d     = rr_q;
    if (push) begin
      wr_ptr_d = (wr_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
      rr_d     = (grant == SRC_W'(NUM_REQ - 1)) ? '0 : grant + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = (rd_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Sequencing: accept in RUN, empty the queue in DRAIN, park in IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (enable && !flush)          state_d = ST_RUN;
      ST_RUN:   if (flush || !enable)          state_d = ST_DRAIN;
      ST_DRAIN: if ((count_q == '0) && !pop)   state_d = ST_IDLE;
      default:                                 state_d = ST_IDLE;
    endcase
  end

  // Control registers with synchronous reset; queue contents are discarded by zeroing count.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (rst) begin
      state_q  <= ST_IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      rr_q     <= '0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      rr_q     <= rr_d;
    end
  end

  // Queue storage write on push.
  always_ff @(posedge clk) begin
    // NOTE: storage is not reset; count_q==0 already marks every entry invalid.
    if (push) begin
      mem_q[wr_ptr_q] <= push_entry;
    end
  end

  a_ready_onehot: assert property (@(posedge clk) disable iff (rst) $onehot0(req_ready));
  a_count_bound:  assert property (@(posedge clk) disable iff (rst) count_q <= CNT_W'(DEPTH));
  a_no_pop_empty: assert property (@(posedge clk) disable iff (rst) !(RE && (count_q == '0)));

endmodule

// File: tb/tb_mt_info_sched.sv
// Directed bench for mt_info_sched: a vector table for the basic round-robin
// flow, then hand-written sequences for full, wrap, flush, reset and fairness.
module tb_mt_info_sched;

  logic         clk = 1'b0;
  logic         rst;
  logic         enable;
  logic         flush;
  logic [3:0]   req_valid;
  logic [127:0] req_data;
  logic [3:0]   req_ready;
  logic         out_valid;
  logic         out_ready;
  logic [31:0]  out_data;
  logic [1:0]   out_src;
  logic         WE;
  logic         RE;
  logic [2:0]   count;
  logic [2:0]   state_check;

  int n_checks = 0;
  int n_pass   = 0;

  mt_info_sched #(.NUM_REQ(4), .DEPTH(5), .DATA_W(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .enable      (enable),
    .flush       (flush),
    .req_valid   (req_valid),
    .req_data    (req_data),
    .req_ready   (req_ready),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_src     (out_src),
    .WE          (WE),
    .RE          (RE),
    .count       (count),
    .state_check (state_check)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        en;
    logic        fl;
    logic [3:0]  rv;
    logic        ordy;
    logic [31:0] base;
    logic [3:0]  e_rdy;
    logic        e_ov;
    logic [31:0] e_data;
    logic [1:0]  e_src;
    logic        e_we;
    logic        e_re;
    logic [2:0]  e_cnt;
    logic [2:0]  e_sc;
  } vec_t;

  vec_t tbl [7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  task automatic set_base(input logic [31:0] base);
    for (int i = 0; i < 4; i++) req_data[i*32 +: 32] = base + 32'(i);
  endtask

  task automatic set_req(input int idx, input logic [31:0] val);
    req_data = '0;
    req_data[idx*32 +: 32] = val;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Basic round-robin flow: all four requesters valid, consumer always ready.
    tbl[0] = '{1'b1, 1'b0, 4'hF, 1'b1, 32'hA0, 4'h0, 1'b0, 32'h0,  2'd0, 1'b0, 1'b0, 3'd0, 3'b000};
    tbl[1] = '{1'b1, 1'b0, 4'hF, 1'b1, 32'hA0, 4'h1, 1'b0, 32'h0,  2'd0, 1'b1, 1'b0, 3'd0, 3'b001};
    tbl[2] = '{1'b1, 1'b0, 4'hF, 1'b1, 32'hA0, 4'h2, 1'b1, 32'hA0, 2'd0, 1'b1, 1'b1, 3'd1, 3'b001};
    tbl[3] = '{1'b1, 1'b0, 4'hF, 1'b1, 32'hA0, 4'h4, 1'b1, 32'hA1, 2'd1, 1'b1, 1'b1, 3'd1, 3'b001};
    tbl[4] = '{1'b1, 1'b0, 4'hF, 1'b1, 32'hA0, 4'h8, 1'b1, 32'hA2, 2'd2, 1'b1, 1'b1, 3'd1, 3'b001};
    tbl[5] = '{1'b1, 1'b0, 4'h0, 1'b1, 32'hA0, 4'h0, 1'b1, 32'hA3, 2'd3, 1'b0, 1'b1, 3'd1, 3'b001};
    tbl[6] = '{1'b1, 1'b0, 4'h0, 1'b1, 32'hA0, 4'h0, 1'b0, 32'h0,  2'd0, 1'b0, 1'b0, 3'd0, 3'b001};

    rst       = 1'b1;
    enable    = 1'b0;
    flush     = 1'b0;
    req_valid = '0;
    req_data  = '0;
    out_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    settle();
    check("reset req_ready",   32'(req_ready),   32'h0);
    check("reset out_valid",   32'(out_valid),   32'h0);
    check("reset WE",          32'(WE),          32'h0);
    check("reset RE",          32'(RE),          32'h0);
    check("reset count",       32'(count),       32'h0);
    check("reset state_check", 32'(state_check), 32'h0);
    tick();

    for (int v = 0; v < 7; v++) begin
      enable    = tbl[v].en;
      flush     = tbl[v].fl;
      req_valid = tbl[v].rv;
      out_ready = tbl[v].ordy;
      set_base(tbl[v].base);
      settle();
      check($sformatf("vec%0d req_ready", v),   32'(req_ready),   32'(tbl[v].e_rdy));
      check($sformatf("vec%0d out_valid", v),   32'(out_valid),   32'(tbl[v].e_ov));
      if (tbl[v].e_ov) begin
        check($sformatf("vec%0d out_data", v),  out_data,         tbl[v].e_data);
        check($sformatf("vec%0d out_src", v),   32'(out_src),     32'(tbl[v].e_src));
      end
      check($sformatf("vec%0d WE", v),          32'(WE),          32'(tbl[v].e_we));
      check($sformatf("vec%0d RE", v),          32'(RE),          32'(tbl[v].e_re));
      check($sformatf("vec%0d count", v),       32'(count),       32'(tbl[v].e_cnt));
      check($sformatf("vec%0d state_check", v), 32'(state_check), 32'(tbl[v].e_sc));
      tick();
    end

    // Fill to full with requester 2 while the consumer stalls.
    out_ready = 1'b0;
    req_valid = 4'b0100;
    for (int k = 0; k < 5; k++) begin
      set_req(2, 32'h100 + 32'(k));
      settle();
      check($sformatf("fill%0d req_ready", k), 32'(req_ready), 32'h4);
      check($sformatf("fill%0d WE", k),        32'(WE),        32'h1);
      tick();
    end
    set_req(2, 32'h105);
    settle();
    check("full req_ready",   32'(req_ready),   32'h0);
    check("full WE",          32'(WE),          32'h0);
    check("full count",       32'(count),       32'd5);
    check("full state_check", 32'(state_check), 32'b101);
    check("full out_data",    out_data,         32'h100);
    check("full out_src",     32'(out_src),     32'd2);
    tick();
    out_ready = 1'b1;
    settle();
    check("full+pop req_ready", 32'(req_ready), 32'h0);
    check("full+pop RE",        32'(RE),        32'h1);
    check("full+pop out_data",  out_data,       32'h100);
    tick();
    settle();
    check("cnt4 req_ready", 32'(req_ready), 32'h4);
    check("cnt4 WE",        32'(WE),        32'h1);
    check("cnt4 RE",        32'(RE),        32'h1);
    check("cnt4 out_data",  out_data,       32'h101);
    check("cnt4 count",     32'(count),     32'd4);
    tick();
    req_valid = 4'b0000;
    settle();
    check("pop102 out_data", out_data,   32'h102);
    check("pop102 count",    32'(count), 32'd4);
    tick();

    // Simultaneous push and pop at count 3, across the write-pointer wrap.
    req_valid = 4'b0100;
    set_req(2, 32'h106);
    settle();
    check("pushpop count",    32'(count), 32'd3);
    check("pushpop WE",       32'(WE),    32'h1);
    check("pushpop RE",       32'(RE),    32'h1);
    check("pushpop out_data", out_data,   32'h103);
    tick();
    req_valid = 4'b0000;
    settle();
    check("after pushpop count", 32'(count), 32'd3);
    check("drain104 out_data",   out_data,   32'h104);
    tick();
    settle();
    check("drain105 out_data", out_data,   32'h105);
    check("drain105 count",    32'(count), 32'd2);
    tick();
    settle();
    check("drain106 out_data", out_data,   32'h106);
    check("drain106 count",    32'(count), 32'd1);
    tick();
    settle();
    check("empty out_valid", 32'(out_valid), 32'h0);
    check("empty count",     32'(count),     32'd0);
    tick();

    // Flush with a pending request: grant blocked, queue drains, then IDLE.
    out_ready = 1'b0;
    req_valid = 4'b0010;
    set_req(1, 32'h201);
    settle();
    check("pre-flush grant0", 32'(req_ready), 32'h2);
    tick();
    set_req(1, 32'h211);
    settle();
    check("pre-flush grant1", 32'(req_ready), 32'h2);
    tick();
    flush = 1'b1;
    settle();
    check("flush req_ready",   32'(req_ready),   32'h0);
    check("flush WE",          32'(WE),          32'h0);
    check("flush count",       32'(count),       32'd2);
    check("flush state_check", 32'(state_check), 32'b001);
    tick();
    flush     = 1'b0;
    enable    = 1'b0;
    out_ready = 1'b1;
    settle();
    check("drain0 state_check", 32'(state_check), 32'b010);
    check("drain0 req_ready",   32'(req_ready),   32'h0);
    check("drain0 RE",          32'(RE),          32'h1);
    check("drain0 out_data",    out_data,         32'h201);
    check("drain0 out_src",     32'(out_src),     32'd1);
    tick();
    settle();
    check("drain1 out_data",    out_data,         32'h211);
    check("drain1 state_check", 32'(state_check), 32'b010);
    tick();
    settle();
    check("drain2 count",       32'(count),       32'd0);
    check("drain2 out_valid",   32'(out_valid),   32'h0);
    check("drain2 state_check", 32'(state_check), 32'b010);
    tick();
    settle();
    check("idle state_check", 32'(state_check), 32'b000);
    check("idle req_ready",   32'(req_ready),   32'h0);
    tick();

    // Reset mid-operation with four entries queued.
    enable    = 1'b1;
    req_valid = 4'b0000;
    out_ready = 1'b0;
    tick();
    req_valid = 4'b1111;
    set_base(32'h300);
    for (int k = 0; k < 4; k++) begin
      settle();
      check($sformatf("prerst grant%0d", k), 32'(req_ready), 32'(4'b0001 << ((k + 2) % 4)));
      tick();
    end
    req_valid = 4'b0000;
    settle();
    check("prerst count",     32'(count),     32'd4);
    check("prerst out_valid", 32'(out_valid), 32'h1);
    check("prerst out_data",  out_data,       32'h302);
    tick();
    rst = 1'b1;
    tick();
    rst       = 1'b0;
    enable    = 1'b0;
    req_valid = 4'b1111;
    settle();
    check("postrst count",       32'(count),       32'd0);
    check("postrst out_valid",   32'(out_valid),   32'h0);
    check("postrst req_ready",   32'(req_ready),   32'h0);
    check("postrst state_check", 32'(state_check), 32'b000);
    tick();
    enable = 1'b1;
    tick();
    settle();
    check("postrst first grant", 32'(req_ready), 32'h1);
    tick();

    // Fairness between requesters 1 and 3.
    req_valid = 4'b1010;
    out_ready = 1'b1;
    for (int k = 0; k < 20; k++) begin
      settle();
      check($sformatf("rr%0d grant", k), 32'(req_ready), (k % 2 == 0) ? 32'h2 : 32'h8);
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
